// File: rtl/axi4_burst_ram_slave.sv
// AXI4 burst slave over a word-addressed dual-port array: independent write and
// read engines with FIXED/INCR/WRAP addressing and per-burst SLVERR latching.
module axi4_burst_ram_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int IW    = C_S_AXI_ID_WIDTH;
  localparam int DEPTH = 1 << (AW - 2);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [31:0] mem [DEPTH];

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                               input logic [1:0] burst);
    logic [AW-1:0] mask;
    logic [AW-1:0] inc;
    mask = AW'((({24'd0, len} + 32'd1) << 2) - 32'd1);
    inc  = addr + AW'(4);
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~mask) | (inc & mask);
      default: next_addr = inc;
    endcase
  endfunction

  function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    burst_err = (size != 3'd2) || (burst == 2'b11) ||
                (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // ---------------- write engine ----------------
  w_state_t      w_state_q, w_state_d;
  logic [IW-1:0] w_id_q, w_id_d, bid_q, bid_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [7:0]    w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [1:0]    w_burst_q, w_burst_d, bresp_q, bresp_d;
  logic          w_err_q, w_err_d;
  logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic          last_beat, beat_err, mem_we;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    last_beat = (w_cnt_q == w_len_q);
    beat_err  = w_err_q || (S_AXI_WLAST != last_beat);
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awready_q && S_AXI_AWVALID) begin
          w_id_d    = S_AXI_AWID;
          w_addr_d  = S_AXI_AWADDR;
          w_len_d   = S_AXI_AWLEN;
          w_burst_d = S_AXI_AWBURST;
          w_cnt_d   = 8'd0;
          w_err_d   = burst_err(S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wready_q && S_AXI_WVALID) begin
          // Once a beat errs, the rest of the burst is accepted but never written.
          w_err_d  = beat_err;
          mem_we   = !beat_err;
          w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
          w_cnt_d  = w_cnt_q + 8'd1;
          if (last_beat) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = beat_err ? RESP_SLVERR : RESP_OKAY;
            bid_d     = w_id_q;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) mem[w_addr_q[AW-1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t      r_state_q, r_state_d;
  logic [IW-1:0] rid_q, rid_d;
  logic [AW-1:0] r_addr_q, r_addr_d, r_load_addr;
  logic [7:0]    r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [1:0]    r_burst_q, r_burst_d, rresp_q, rresp_d;
  logic          r_err_q, r_err_d, ar_err;
  logic          arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0]   rdata_q, rdata_d, r_word;

  // Address of the word loaded into RDATA this cycle: burst start on AR, else the next beat.
  always_comb begin
    r_load_addr = (r_state_q == R_IDLE) ? S_AXI_ARADDR : next_addr(r_addr_q, r_len_q, r_burst_q);
    ar_err      = burst_err(S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
  end

  assign r_word = mem[r_load_addr[AW-1:2]];

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_burst_d = r_burst_q;
    r_err_d   = r_err_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arready_q && S_AXI_ARVALID) begin
          rid_d     = S_AXI_ARID;
          r_addr_d  = S_AXI_ARADDR;
          r_len_d   = S_AXI_ARLEN;
          r_burst_d = S_AXI_ARBURST;
          r_cnt_d   = 8'd0;
          r_err_d   = ar_err;
          rdata_d   = ar_err ? 32'd0 : r_word;
          rresp_d   = ar_err ? RESP_SLVERR : RESP_OKAY;
          rlast_d   = (S_AXI_ARLEN == 8'd0);
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_addr_d = r_load_addr;
            r_cnt_d  = r_cnt_q + 8'd1;
            rdata_d  = r_err_q ? 32'd0 : r_word;
            rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_burst_q <= r_burst_d;
      r_err_q   <= r_err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RID     = rid_q;
endmodule

// File: tb/tb_axi4_burst_ram_slave.sv
// Randomized bench for axi4_burst_ram_slave: drivers push expected B/R responses,
// a negedge monitor pops and compares them against a word-array reference model.
module tb_axi4_burst_ram_slave;
  localparam int WORDS = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [0:0]  awid, bid, arid, rid;
  logic [9:0]  awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  axi4_burst_ram_slave dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  typedef struct packed {logic [31:0] d; logic [1:0] resp; logic last; logic id;} rexp_t;
  typedef struct packed {logic [1:0] resp; logic id;} bexp_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model [WORDS];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  rexp_t       exp_r[$];
  bexp_t       exp_b[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  function automatic void fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no handshake within budget, want handshake", name);
  endfunction

  // Word index of beat i, straight from the burst rules.
  function automatic int beat_word(input int addr, input int len, input int burst, input int i);
    int span, base, a;
    case (burst)
      0: a = addr;
      2: begin
        span = (len + 1) * 4;
        base = addr - (addr % span);
        a    = base + ((addr - base + 4 * i) % span);
      end
      default: a = addr + 4 * i;
    endcase
    return (a % 1024) / 4;
  endfunction

  function automatic bit is_err(input int len, input int size, input int burst);
    return (size != 2) || (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15}));
  endfunction

  function automatic bit wlast_of(input int i, input int len, input int bad_beat);
    return (bad_beat < 0) ? (i == len) : (i == bad_beat);
  endfunction

  task automatic wait_sig(input int which, input string name, output int waited);
    bit s;
    waited = 0;
    forever begin
      @(negedge clk);
      case (which)
        0: s = awready;
        1: s = wready;
        2: s = bvalid;
        default: s = arready;
      endcase
      if (s) break;
      waited++;
      if (waited > 100) begin
        fail_timeout(name);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_write(input int id, input int addr, input int len, input int size, input int burst,
                          input int bad_beat, input int abort_after, input bit gaps);
    int beats, first_err, lim, w, n, waits;
    bexp_t e;
    beats     = len + 1;
    first_err = is_err(len, size, burst) ? 0 : beats;
    for (int i = 0; i < beats; i++)
      if (i < first_err && wlast_of(i, len, bad_beat) != (i == len)) first_err = i;
    lim = (abort_after >= 0) ? abort_after : beats;
    for (int i = 0; i < lim && i < first_err; i++) begin
      w = beat_word(addr, len, burst, i);
      for (int b = 0; b < 4; b++) if (ws[i][b]) model[w][8*b +: 8] = wd[i][8*b +: 8];
    end
    if (abort_after < 0) begin
      e.resp = (first_err < beats) ? 2'b10 : 2'b00;
      e.id   = 1'(id);
      exp_b.push_back(e);
    end
    $display("WR id=%0d addr=%03h len=%0d size=%0d burst=%0d badlast=%0d abort=%0d", id, addr, len, size,
             burst, bad_beat, abort_after);
    awid = 1'(id); awaddr = 10'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    wait_sig(0, "aw", n);
    @(posedge clk); #1;
    awvalid = 1'b0;
    waits = 0;
    for (int i = 0; i < beats; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        wvalid = 1'b0;
        @(posedge clk); #1;
      end
      wdata = wd[i]; wstrb = ws[i]; wlast = wlast_of(i, len, bad_beat); wvalid = 1'b1;
      if (i == abort_after) begin
        #2 rst_n = 1'b0;
        wvalid = 1'b0;
        return;
      end
      wait_sig(1, "w", n);
      waits += n;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("w_stall_cycles", 64'(waits), 64'd0);
    @(negedge clk);
    chk("wready_after_last", 64'(wready), 64'd0);
    chk("bvalid_after_last", 64'(bvalid), 64'd1);
    @(posedge clk); #1;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    bready = 1'b1;
    wait_sig(2, "b", n);
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("awready_after_b", 64'(awready), 64'd1);
    chk("bvalid_after_b", 64'(bvalid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input int id, input int addr, input int len, input int size, input int burst,
                         input int mode);
    bit    err;
    int    got, cyc, n;
    rexp_t e;
    err = is_err(len, size, burst);
    for (int i = 0; i <= len; i++) begin
      e.d    = err ? 32'd0 : model[beat_word(addr, len, burst, i)];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == len);
      e.id   = 1'(id);
      exp_r.push_back(e);
    end
    $display("RD id=%0d addr=%03h len=%0d size=%0d burst=%0d mode=%0d", id, addr, len, size, burst, mode);
    arid = 1'(id); araddr = 10'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    wait_sig(3, "ar", n);
    @(posedge clk); #1;
    arvalid = 1'b0;
    got = 0;
    cyc = 0;
    while (got < len + 1 && cyc < 200) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (cyc == 0) chk("rvalid_after_ar", 64'(rvalid), 64'd1);
      chk("arready_busy", 64'(arready), 64'd0);
      if (rvalid && rready) got++;
      cyc++;
      @(posedge clk); #1;
    end
    rready = 1'b0;
    chk("r_beats", 64'(got), 64'(len + 1));
    if (mode == 0) chk("r_full_rate", 64'(cyc), 64'(len + 1));
    @(negedge clk);
    chk("arready_after_last", 64'(arready), 64'd1);
    chk("rvalid_after_last", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    @(negedge clk);
    chk("awready_low_post_rst", 64'(awready), 64'd0);
    chk("arready_low_post_rst", 64'(arready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("awready_rise", 64'(awready), 64'd1);
    chk("arready_rise", 64'(arready), 64'd1);
    @(posedge clk); #1;
  endtask

  // Monitor: compares every B and R handshake, and RDATA/RLAST stability under stall.
  logic        prev_rv = 1'b0, prev_hs = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_d = '0;
  always @(negedge clk) begin
    bexp_t be;
    rexp_t re;
    if (!rst_n) begin
      exp_b.delete();
      exp_r.delete();
      chk("reset_values", 64'({awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rdata, rresp, rid}),
          64'd0);
      prev_rv <= 1'b0;
      prev_hs <= 1'b0;
    end else begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) chk("b_expected", 64'd0, 64'd1);
        else begin
          be = exp_b.pop_front();
          chk("bresp", 64'(bresp), 64'(be.resp));
          chk("bid", 64'(bid), 64'(be.id));
        end
      end
      if (rvalid && prev_rv && !prev_hs) begin
        chk("rdata_hold", 64'(rdata), 64'(prev_d));
        chk("rlast_hold", 64'(rlast), 64'(prev_last));
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) chk("r_expected", 64'd0, 64'd1);
        else begin
          re = exp_r.pop_front();
          chk("rdata", 64'(rdata), 64'(re.d));
          chk("rresp", 64'(rresp), 64'(re.resp));
          chk("rlast", 64'(rlast), 64'(re.last));
          chk("rid", 64'(rid), 64'(re.id));
        end
      end
      prev_rv   <= rvalid;
      prev_hs   <= rvalid && rready;
      prev_d    <= rdata;
      prev_last <= rlast;
    end
  end

  initial begin
    int op, len, burst, size, addr, id, bb;
    rst_n = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    release_reset();

    // Preload the whole array so every later read has a known reference.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(0, k * 64, 15, 2, 1, -1, -1, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(0, 0, 7, 2, 1, -1, -1, 1'b0);
    do_read(0, 0, 7, 2, 1, 0);

    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(1, 'h10, 0, 2, 1, -1, -1, 1'b0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
    do_write(0, 'h10, 0, 2, 1, -1, -1, 1'b0);
    do_read(1, 'h10, 0, 2, 1, 0);

    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    do_write(0, 'h08, 3, 2, 2, -1, -1, 1'b0);
    do_read(0, 'h08, 3, 2, 2, 0);
    do_read(1, 'h00, 3, 2, 1, 0);

    do_read(1, 0, 7, 2, 1, 1);

    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(0, 'h20, 3, 2, 1, 1, -1, 1'b0);
    do_read(0, 'h20, 3, 2, 1, 0);
    do_read(0, 'h20, 3, 1, 1, 0);

    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    fork
      do_write(1, 'h40, 7, 2, 1, -1, -1, 1'b0);
      do_read(0, 'h80, 7, 2, 1, 0);
    join

    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(0, 'h40, 7, 2, 1, -1, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    release_reset();
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    fork
      do_write(0, 'hC0, 7, 2, 1, -1, -1, 1'b0);
      do_read(1, 'h40, 7, 2, 1, 0);
    join

    for (int t = 0; t < 40; t++) begin
      op    = $urandom_range(0, 1);
      burst = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) burst = 3;
      len = $urandom_range(0, 15);
      if (burst == 2 && $urandom_range(0, 4) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      size = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : 2;
      addr = $urandom_range(0, 255) * 4;
      id   = $urandom_range(0, 1);
      if (op == 1) begin
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        bb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
        do_write(id, addr, len, size, burst, bb, -1, 1'b1);
      end else begin
        do_read(id, addr, len, size, burst, 2);
      end
    end

    repeat (3) @(posedge clk);
    chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
    chk("r_queue_drained", 64'(exp_r.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
